// File: rtl/bus_pkg.sv
// Shared command/status encodings and FSM state type for the bus arbiter.
package bus_pkg;

  localparam logic [1:0] CMD_WAIT   = 2'b00;
  localparam logic [1:0] CMD_STOP_S = 2'b01;
  localparam logic [1:0] CMD_STOP_P = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [1:0] CS_END_COM  = 2'b00;
  localparam logic [1:0] CS_NAK      = 2'b01;
  localparam logic [1:0] CS_WAIT_ACK = 2'b10;
  localparam logic [1:0] CS_COM      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ACK,
    ST_COM,
    ST_RELEASE
  } arb_state_t;

  // Slave IDs run 1..n_slaves; 0 and out-of-range values are not requests.
  function automatic logic req_valid(input int id, input int n_slaves);
    return (id != 0) && (id <= n_slaves);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the bus masters and the arbiter.
interface bus_arbiter_if #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
);

  logic [S_ID_WIDTH-1:0]            req_id    [NO_MASTERS];
  logic [NO_MASTERS-1:0]            prio;
  logic [1:0]                       com_state [NO_MASTERS];
  logic [1:0]                       cmd       [NO_MASTERS];
  logic [NO_MASTERS-1:0]            grant;
  logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state;
  logic                             bus_busy;
  logic                             timeout;

  modport master (
    output req_id, prio, com_state,
    input  cmd, grant, bus_state, bus_busy, timeout
  );

  modport slave (
    input  req_id, prio, com_state,
    output cmd, grant, bus_state, bus_busy, timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req after index last.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter/sequencer with watchdog.
// Optional priority preemption is enabled by defining BUS_ARB_PREEMPT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int THRESH     = 1000,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input  logic          clk,
  input  logic          rstN,
  bus_arbiter_if.slave  bus
);

  localparam int WD_W = $clog2(THRESH + 1);
  localparam int BS_W = S_ID_WIDTH + M_ID_WIDTH;

  arb_state_t            state_q, state_d;
  logic [M_ID_WIDTH-1:0] cur_master_q, cur_master_d;
  logic [M_ID_WIDTH-1:0] last_master_q, last_master_d;
  logic [S_ID_WIDTH-1:0] cur_slave_q, cur_slave_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NO_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]            cmd_q [NO_MASTERS];
  logic [1:0]            cmd_d [NO_MASTERS];
  logic [BS_W-1:0]       bus_state_q, bus_state_d;
  logic                  bus_busy_q, bus_busy_d;
  logic                  timeout_q, timeout_d;

  logic [NO_MASTERS-1:0] valid;
  logic                  pick_found;
  logic [M_ID_WIDTH-1:0] pick_idx;
  logic                  preempt;
  logic [1:0]            cs;

  always_comb begin
    for (int m = 0; m < NO_MASTERS; m++)
      valid[m] = req_valid(int'(bus.req_id[m]), NO_SLAVES);
  end

  assign cs = bus.com_state[cur_master_q];

`ifdef BUS_ARB_PREEMPT_EN
  logic                  hi_found, lo_found;
  logic [M_ID_WIDTH-1:0] hi_idx, lo_idx;

  rr_picker #(.N(NO_MASTERS), .IW(M_ID_WIDTH)) u_pick_hi (
    .req   (valid & bus.prio),
    .last  (last_master_q),
    .found (hi_found),
    .idx   (hi_idx)
  );

  rr_picker #(.N(NO_MASTERS), .IW(M_ID_WIDTH)) u_pick_lo (
    .req   (valid),
    .last  (last_master_q),
    .found (lo_found),
    .idx   (lo_idx)
  );

  assign pick_found = hi_found | lo_found;
  assign pick_idx   = hi_found ? hi_idx : lo_idx;

  // A low-priority owner is asked to stop when any other priority requester waits.
  always_comb begin
    preempt = 1'b0;
    for (int m = 0; m < NO_MASTERS; m++)
      if (M_ID_WIDTH'(m) != cur_master_q && valid[m] && bus.prio[m] && !bus.prio[cur_master_q])
        preempt = 1'b1;
  end
`else
  logic prio_unused;

  rr_picker #(.N(NO_MASTERS), .IW(M_ID_WIDTH)) u_pick (
    .req   (valid),
    .last  (last_master_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign prio_unused = ^bus.prio;
  assign preempt     = 1'b0;
`endif

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_comb begin
    state_d       = state_q;
    cur_master_d  = cur_master_q;
    cur_slave_d   = cur_slave_q;
    last_master_d = last_master_q;
    wd_d          = wd_q;
    grant_d       = '0;
    bus_state_d   = '0;
    bus_busy_d    = 1'b0;
    timeout_d     = 1'b0;
    for (int m = 0; m < NO_MASTERS; m++) cmd_d[m] = CMD_WAIT;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          cur_master_d = pick_idx;
          cur_slave_d  = bus.req_id[pick_idx];
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_d[cur_master_q] = 1'b1;
        cmd_d[cur_master_q]   = CMD_CLEAR;
        bus_busy_d            = 1'b1;
        wd_d                  = '0;
        state_d               = ST_ACK;
      end
      ST_ACK: begin
        grant_d[cur_master_q] = 1'b1;
        cmd_d[cur_master_q]   = CMD_CLEAR;
        bus_busy_d            = 1'b1;
        if (cs == CS_COM) begin
          wd_d    = '0;
          state_d = ST_COM;
        end else if (cs == CS_NAK) begin
          state_d = ST_RELEASE;
        end else if (wd_q >= WD_W'(THRESH - 1)) begin
          wd_d      = WD_W'(THRESH);
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_COM: begin
        grant_d[cur_master_q] = 1'b1;
        bus_busy_d            = 1'b1;
        bus_state_d           = {cur_master_q, cur_slave_q};
        if (cs == CS_END_COM) begin
          state_d = ST_RELEASE;
        end else begin
          // Saturating count keeps the timeout to a single pulse per grant.
          if (wd_q == WD_W'(THRESH - 1)) begin
            wd_d      = WD_W'(THRESH);
            timeout_d = 1'b1;
          end else if (wd_q != WD_W'(THRESH)) begin
            wd_d = wd_q + 1'b1;
          end
          if (wd_d == WD_W'(THRESH))
            cmd_d[cur_master_q] = CMD_STOP_S;
          else if (preempt)
            cmd_d[cur_master_q] = CMD_STOP_P;
        end
      end
      ST_RELEASE: begin
        last_master_d = cur_master_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q       <= ST_IDLE;
      cur_master_q  <= '0;
      cur_slave_q   <= '0;
      last_master_q <= M_ID_WIDTH'(NO_MASTERS - 1);
      wd_q          <= '0;
      grant_q       <= '0;
      bus_state_q   <= '0;
      bus_busy_q    <= 1'b0;
      timeout_q     <= 1'b0;
      for (int m = 0; m < NO_MASTERS; m++) cmd_q[m] <= CMD_WAIT;
    end else begin
      state_q       <= state_d;
      cur_master_q  <= cur_master_d;
      cur_slave_q   <= cur_slave_d;
      last_master_q <= last_master_d;
      wd_q          <= wd_d;
      grant_q       <= grant_d;
      bus_state_q   <= bus_state_d;
      bus_busy_q    <= bus_busy_d;
      timeout_q     <= timeout_d;
      for (int m = 0; m < NO_MASTERS; m++) cmd_q[m] <= cmd_d[m];
    end
  end

  assign bus.grant     = grant_q;
  assign bus.cmd       = cmd_q;
  assign bus.bus_state = bus_state_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and bus sequencer for the shared serial bus. Collects slave-ID requests from all masters, grants the bus to one master at a time, and runs the CLEAR/acknowledge/communicate/release handshake through per-master `cmd` and `com_state`. Drives `bus_state` = {master, slave}, which sets the address/MOSI/MISO/valid/last/ready mux selects. A watchdog stops a stalled or over-long transfer after `THRESH` cycles.

## Interface
- `NO_MASTERS`, 2: number of masters; must be ≥ 2.
- `NO_SLAVES`, 3: number of slaves; slave IDs are 1..NO_SLAVES.
- `THRESH`, 1000: watchdog limit in cycles.
- `S_ID_WIDTH`, `$clog2(NO_SLAVES+1)`: slave ID width.
- `M_ID_WIDTH`, `$clog2(NO_MASTERS)`: master index width.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rstN` in 1: reset, synchronous and active-low.
- `req_id[NO_MASTERS]` in S_ID_WIDTH: requested slave. 0 means no request; a value above NO_SLAVES is ignored.
- `prio` in NO_MASTERS: per-master high-priority flag. Used only when `BUS_ARB_PREEMPT_EN` is defined.
- `com_state[NO_MASTERS]` in 2: master status. 00 = end_com, 01 = nak, 10 = wait_ack, 11 = com.
- `cmd[NO_MASTERS]` out 2: command to each master. 00 = WAIT, 01 = STOP_S, 10 = STOP_P, 11 = CLEAR.
- `grant` out NO_MASTERS: one-hot bus grant.
- `bus_state` out S_ID_WIDTH+M_ID_WIDTH: {master, slave}; all-zero when idle.
- `bus_busy` out 1: high from GRANT through COM.
- `timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- **States:** IDLE, GRANT, ACK, COM, RELEASE.
- **IDLE:**
  - A master with a valid `req_id` is a candidate.
  - The winner is the first candidate after `last_master`, searching round-robin.
  - On a win: latch `cur_master` and `cur_slave`, then go to GRANT.
  - With no valid request, stay in IDLE.
- **GRANT:**
  - Assert `grant[cur_master]` and `cmd[cur_master]` = CLEAR.
  - Clear the watchdog, then go to ACK.
- **ACK:** keep `cmd` = CLEAR.
  - com → load `bus_state` = {cur_master, cur_slave}, go to COM.
  - nak → go to RELEASE.
  - wait_ack or end_com → stay; the watchdog counts.
  - Watchdog reaches THRESH → pulse `timeout`, go to RELEASE.
- **COM:** `cmd` = WAIT; the watchdog is cleared on entry.
  - end_com → go to RELEASE.
  - Watchdog reaches THRESH → pulse `timeout` once and drive `cmd` = STOP_S. Stay in COM until end_com.
- **RELEASE:**
  - Set `bus_state` = 0, `grant` = 0, `cmd` = WAIT.
  - Set `last_master` = `cur_master`, then go to IDLE.
- **Non-granted masters:** `cmd` is WAIT and their `com_state` is ignored.
- **Request changes after latch:** ignored until IDLE; the granted master must nak to withdraw.
- **Watchdog:** width `$clog2(THRESH+1)`. It saturates at THRESH, so `timeout` pulses at most once per grant.
- **Reset:** rstN low at any edge, in any state, restores reset values on that edge.
  - No RELEASE cycle is produced.
  - A grant in progress is dropped.

## Timing
- **Reset values:**
  - State IDLE; `grant`, `bus_state`, `bus_busy`, `timeout` = 0; all `cmd` = WAIT.
  - `last_master` = NO_MASTERS-1, so master 0 wins first.
- **Registered outputs:** all outputs are registered.
- **Grant path:**
  - Request sampled in IDLE at edge N.
  - `grant` and CLEAR are visible after edge N+1.
  - com sampled in ACK at edge M gives `bus_state` valid after M+1.
- **Release path:**
  - end_com sampled at edge K gives `bus_state` = 0 after K+1.
  - The earliest next grant is after K+3.
- **Minimum grant-to-grant time:** 4 cycles.
- **Simultaneous requests:** exactly one `grant` bit is ever high.

## Configuration
- Macro: `BUS_ARB_PREEMPT_EN`.
- **Defined:**
  - IDLE selects round-robin among candidates with `prio` = 1 first, then among the rest.
  - In COM, if the current master has `prio` = 0 and another candidate has `prio` = 1, drive `cmd` = STOP_P.
  - On end_com, go to RELEASE; the priority master wins the next IDLE.
  - The STOP_S watchdog stop takes precedence over STOP_P.
- **Undefined:**
  - `prio` is ignored and STOP_P is never issued.
  - Behaviour is plain round-robin with the watchdog.

## Structure
- Package `bus_pkg` holds:
  - `cmd` constants WAIT/STOP_S/STOP_P/CLEAR;
  - `com_state` constants end_com/nak/wait_ack/com;
  - `arb_state_t` enum.
- One sub-module, `rr_picker`: combinational round-robin pick from a request mask and a last-index input.
  - Outputs: `found` and the winning index.
  - Instantiated once without the macro, twice with it (priority mask, full mask).

## Test plan
- **Single request:** reset, then master 1 `req_id` = 2, com after 3 cycles.
  - `grant` = 10 and `cmd[1]` = CLEAR one cycle after the request.
  - `bus_state` = {1, 2}; end_com → `bus_state` = 0 and `cmd[1]` = WAIT.
- **Contention:** both masters request slave 3 continuously, each with ack, then end_com after 5 cycles.
  - Grants alternate 0, 1, 0, 1; `grant` is never 11.
- **Nak:** master 0 requests slave 1 and naks.
  - RELEASE, `bus_state` stays 0, and the next grant goes to master 1 if it is requesting.
- **Watchdog:** THRESH = 8, master 0 holds wait_ack → `timeout` pulses after 8 ACK cycles, then release.
  - Separately, hold com for 8 cycles → `cmd[0]` = STOP_S and `timeout` pulses once; end_com → release.
- **Preemption (macro defined):** master 0 (`prio` = 0) in COM, master 1 raises `prio` = 1 with a request.
  - `cmd[0]` = STOP_P next cycle; end_com → master 1 granted.
  - Rerun without the macro → `cmd[0]` stays WAIT.
- **Reset mid-transfer:** rstN low for one cycle while in COM.
  - Next edge shows all outputs at reset values and state IDLE; master 0 wins the next arbitration.
